// File: rtl/fc_argmax_sched_if.sv
// Handshake bundle for the argmax scheduler: score input stream, start/busy
// control, and the classified result output.
interface fc_argmax_sched_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
);
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic        [IDX_W-1:0]  classified;
    logic signed [DATA_W-1:0] max_value;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, busy, out_valid, classified, max_value
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, busy, out_valid, classified, max_value
    );
endinterface

// File: rtl/fc_argmax_sched.sv
// Sequential argmax over N_CLASSES signed scores using one comparator,
// sequenced by an IDLE/SCAN/DONE FSM with valid/ready on both sides.
module fc_argmax_sched #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 4
) (
    input logic                clk,
    input logic                rst,
    fc_argmax_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    state_t                   state_q;
    state_t                   state_d;
    logic        [IDX_W-1:0]  count_p0;
    logic        [IDX_W-1:0]  idx_p0;
    logic signed [DATA_W-1:0] max_p0;

    logic in_ready_c;
    logic busy_c;
    logic out_valid_c;
    logic accept;
    logic last_beat;
    logic take_beat;

    function automatic logic score_gt(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return a > b;
    endfunction

    assign accept    = bus.in_valid && in_ready_c;
    assign last_beat = accept && (count_p0 == LAST_IDX);
    // The first beat seeds the running max regardless of its value; later
    // beats replace it only when strictly larger, so ties keep the lower index.
    assign take_beat = accept && ((count_p0 == '0) || score_gt(bus.in_data, max_p0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)     state_d = SCAN;
            SCAN:    if (last_beat)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = 1'b0;
        busy_c      = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            SCAN: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b1;
            end
            DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Stage p0: running count, best index and best score
    always_ff @(posedge clk) begin
        if (rst) begin
            count_p0 <= '0;
            idx_p0   <= '0;
            max_p0   <= '0;
        end else begin
            if (state_q == IDLE && bus.start) begin
                count_p0 <= '0;
            end else if (accept) begin
                count_p0 <= last_beat ? '0 : count_p0 + 1'b1;
            end
            if (take_beat) begin
                idx_p0 <= count_p0;
                max_p0 <= bus.in_data;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.busy       = busy_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.classified = idx_p0;
    assign bus.max_value  = max_p0;

endmodule

// File: tb/tb_fc_argmax_sched.sv
// Directed and randomized bench for fc_argmax_sched against a plain
// find-max-then-first-index reference model.
module tb_fc_argmax_sched;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    typedef logic signed [DW-1:0] score_t;
    typedef score_t score_arr_t [N];

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    fc_argmax_sched_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    fc_argmax_sched #(.N_CLASSES(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_model(input score_arr_t s, output int idx, output score_t mx);
        mx = s[0];
        foreach (s[i]) if (s[i] > mx) mx = s[i];
        idx = -1;
        foreach (s[i]) if (idx < 0 && s[i] == mx) idx = i;
    endfunction

    // vmode 0: in_valid always high; 1: pattern 1,0,0,1,0,0...; 2: random.
    // poke: pulse start mid-scan and during DONE, and drive in_valid in DONE.
    task automatic run_scan(input string tag, input score_arr_t s, input int exp_idx,
                            input score_t exp_max, input int vmode, input int hold,
                            input bit poke);
        int  k     = 0;
        int  edges = 0;
        int  cyc   = 0;
        bit  acc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, ".busy_scan"}, 32'(bus.busy), 32'd1);
        check({tag, ".in_ready_scan"}, 32'(bus.in_ready), 32'd1);
        while (!bus.out_valid && edges < 200) begin
            case (vmode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = (cyc % 3 == 0);
                default: bus.in_valid = 1'($urandom_range(1, 0));
            endcase
            bus.in_data = (k < N) ? s[k] : score_t'(0);
            bus.start   = poke && (cyc == 3);
            acc = bus.in_valid && bus.in_ready;
            tick();
            edges++;
            cyc++;
            if (acc) k++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check({tag, ".out_valid_seen"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".beats_taken"}, 32'(k), 32'(N));
        if (vmode == 0) check({tag, ".latency"}, 32'(edges), 32'(N));
        check({tag, ".classified"}, 32'(bus.classified), 32'(exp_idx));
        check({tag, ".max_value"}, 32'(bus.max_value), 32'(exp_max));
        bus.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            bus.start    = poke && (h == 0);
            bus.in_valid = poke;
            tick();
            check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".hold_idx"}, 32'(bus.classified), 32'(exp_idx));
            check({tag, ".hold_max"}, 32'(bus.max_value), 32'(exp_max));
            check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".idle_keep_idx"}, 32'(bus.classified), 32'(exp_idx));
        tick();
        check({tag, ".idle_stays"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        score_arr_t s1;
        score_arr_t s;
        int         ridx;
        score_t     rmax;

        s1 = '{16'h000B, 16'h0002, 16'h000C, 16'h0001, 16'h0009,
               16'h0004, 16'h000D, 16'h000F, 16'h000A, 16'h0000};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset.in_ready", 32'(bus.in_ready), 32'd0);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.classified", 32'(bus.classified), 32'd0);
        check("reset.max_value", 32'(bus.max_value), 32'd0);

        run_scan("s1", s1, 7, 16'sh000F, 0, 0, 1'b0);

        s = s1;
        s[7] = 16'h0000;
        run_scan("s2a", s, 6, 16'sh000D, 0, 0, 1'b0);
        s = s1;
        s[0] = 16'h000F;
        run_scan("s2tie", s, 0, 16'sh000F, 0, 0, 1'b0);

        s = '{16'h8000, 16'hFFF0, 16'hC000, 16'hFF00, 16'hFFFE,
              16'h8001, 16'hFFF0, 16'hA000, 16'hF000, 16'hFFEF};
        run_scan("s3neg", s, 4, 16'shFFFE, 0, 0, 1'b0);
        foreach (s[i]) s[i] = 16'h8000;
        s[9] = 16'h7FFF;
        run_scan("s3ext", s, 9, 16'sh7FFF, 0, 0, 1'b0);

        run_scan("s4bp", s1, 7, 16'sh000F, 1, 5, 1'b0);
        run_scan("s5poke", s1, 7, 16'sh000F, 0, 3, 1'b1);

        bus.in_valid = 1'b1;
        bus.in_data  = 16'sh7FFF;
        repeat (3) begin
            tick();
            check("idle_inv.in_ready", 32'(bus.in_ready), 32'd0);
            check("idle_inv.busy", 32'(bus.busy), 32'd0);
            check("idle_inv.out_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.in_valid = 1'b0;
        check("idle_inv.keep_max", 32'(bus.max_value), 32'h0000000F);
        s = s1;
        s[0] = 16'h0010;
        run_scan("s5after", s, 0, 16'sh0010, 0, 0, 1'b0);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = s1[b];
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = s1[5];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_mid.in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mid.busy", 32'(bus.busy), 32'd0);
        check("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid.classified", 32'(bus.classified), 32'd0);
        check("rst_mid.max_value", 32'(bus.max_value), 32'd0);
        run_scan("s6fresh", s1, 7, 16'sh000F, 0, 0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            bit narrow = 1'($urandom_range(1, 0));
            foreach (s[i]) s[i] = narrow ? score_t'($urandom_range(3, 0)) - score_t'(1)
                                         : score_t'($urandom);
            ref_model(s, ridx, rmax);
            run_scan($sformatf("rnd%0d", r), s, ridx, rmax,
                     int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                     1'($urandom_range(1, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fc_argmax_sched.md
Name: fc_argmax_sched

Overview:
- Sequential argmax controller for the FC-layer classification stage.
- Accepts the N_CLASSES neuron output scores one per handshake from the FC-layer output stream, in class-index order 0..N_CLASSES-1.
- Tracks the running maximum and its index, then presents the winning class index and score through a valid/ready output handshake.
- Replaces a wide combinational 10-way compare with a single comparator, sequenced by a start/busy/done FSM.

Parameters:
- N_CLASSES, 10, number of class scores per inference (≥2).
- DATA_W, 16, score width; two's-complement signed fixed point.
- IDX_W, 4, class index width; must satisfy 2^IDX_W ≥ N_CLASSES.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  one-cycle request to begin a new scan; honoured only in IDLE.
- in_valid  input  1  score on in_data is valid.
- in_data  input  DATA_W  signed score for class index = current count.
- in_ready  output  1  block accepts a score this cycle.
- busy  output  1  high in SCAN or DONE.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- classified  output  IDX_W  index of the maximum score.
- max_value  output  DATA_W  maximum score.

Behaviour:
- Reset (rst=1 at an edge) forces state=IDLE, count=0, in_ready=0, busy=0, out_valid=0, classified=0, max_value=0. Reset takes priority over all other inputs, including mid-scan and mid-output.
- States: IDLE, SCAN, DONE. All outputs are registered or decoded from state only; there is no combinational path from in_* to out_*.
- IDLE: in_ready=0, out_valid=0, busy=0. If start=1, go to SCAN next cycle with count=0. classified and max_value keep the last result.
- SCAN: in_ready=1, busy=1. A beat is accepted when in_valid=1 and in_ready=1.
  - On an accepted beat with count==0: max_value<=in_data and classified<=0 unconditionally.
  - On an accepted beat with count>0: update only if in_data > max_value (signed, strict).
  - Ties keep the lower index.
  - count increments on every accepted beat.
  - in_valid=0 stalls the scan; there is no timeout.
- Last beat: the beat accepted with count==N_CLASSES-1 moves the FSM to DONE on the same edge. count wraps to 0.
- DONE: out_valid=1, busy=1, in_ready=0. classified and max_value are stable while out_valid=1 and out_ready=0. When out_ready=1, go to IDLE next cycle.
- Latency: out_valid rises the cycle after the last accepted beat. With continuous in_valid, start-to-out_valid is N_CLASSES+1 cycles (11 with defaults).
- start while in SCAN or DONE is ignored and not queued.
- start asserted in the same cycle the FSM returns to IDLE is not seen. The next start must arrive while in IDLE. Back-to-back inferences therefore have at least one IDLE cycle between them.
- in_valid while in IDLE or DONE is ignored; no beat is consumed.
- Comparison is a full DATA_W-bit signed compare. No truncation and no saturation.

Test Plan:
1. Reset, start, then stream indices 0..9 = 0x000B,0x0002,0x000C,0x0001,0x0009,0x0004,0x000D,0x000F,0x000A,0x0000 with in_valid always high -> out_valid 11 cycles after start, classified=7, max_value=0x000F.
2. Same stream with index7=0x0000 -> classified=6, max_value=0x000D. Then the same stream with index0=0x000F and index7=0x000F -> tie resolves to classified=0, max_value=0x000F.
3. Signed: all scores negative, with index4=0xFFFE (-2) and the rest 0x8000..0xFFF0 -> classified=4, max_value=0xFFFE. Also 0x7FFF at index9 vs 0x8000 elsewhere -> classified=9.
4. Backpressure: in_valid toggles 1,0,0,1,… across the scenario 1 data -> identical result, count advances only on accepted beats. Then hold out_ready=0 for 5 cycles -> out_valid, classified and max_value remain stable; the cycle after out_ready=1 the FSM is in IDLE with out_valid=0.
5. start pulsed mid-SCAN and during DONE -> no restart, result unchanged. in_valid high in IDLE -> in_ready=0, no state change.
6. Assert rst after 5 accepted beats -> next cycle all outputs are 0 and the FSM is in IDLE. A fresh start plus the scenario 1 stream -> classified=7.
